// File: rtl/linear_output_packer.sv
// linear_output_packer
// Collects the requantised results of the linear-layer multiplier into
// multi-lane words, buffers complete words in a FIFO and streams them out
// on a valid/ready interface with per-lane keep and end-of-frame marking.
// An early stall warning lets the controller stop issuing beats before the
// FIFO fills; words that still arrive when it is full are dropped and
// recorded in a sticky overflow flag.
module linear_output_packer #(
    parameter int PRECISION      = 8,
    parameter int NUM_FEATURES   = 2,
    parameter int BYTES_PER_WORD = 4,
    parameter int ROWS_PER_FRAME = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int AFULL_SLACK    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    input  logic [NUM_FEATURES-1:0][PRECISION-1:0]   in_data,
    output logic                                     stall,
    output logic [BYTES_PER_WORD*PRECISION-1:0]      m_data,
    output logic [BYTES_PER_WORD-1:0]                m_keep,
    output logic                                     m_last,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic                                     overflow
);

    localparam int WORD_W = BYTES_PER_WORD * PRECISION;
    // Lane pointer is one bit wider than the lane index so lane+offset never wraps.
    localparam int LANE_W = $clog2(BYTES_PER_WORD) + 1;
    localparam int ROW_W  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    // Occupancy counter must represent FIFO_DEPTH itself.
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [LANE_W-1:0] LANE_ZERO = LANE_W'(0);
    localparam logic [LANE_W-1:0] LANE_STEP = LANE_W'(NUM_FEATURES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - NUM_FEATURES);
    localparam logic [ROW_W-1:0]  ROW_ZERO  = ROW_W'(0);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS_PER_FRAME - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(FIFO_DEPTH - AFULL_SLACK);

    // Pack register and its pointers
    logic [BYTES_PER_WORD-1:0][PRECISION-1:0] pack_data_q, pack_data_d;
    logic [BYTES_PER_WORD-1:0]                pack_keep_q, pack_keep_d;
    logic [LANE_W-1:0]                        lane_q, lane_d;
    logic [ROW_W-1:0]                         row_q, row_d;

    // Pack register merged with the current beat
    logic [BYTES_PER_WORD-1:0][PRECISION-1:0] word_data_s;
    logic [BYTES_PER_WORD-1:0]                word_keep_s;
    logic                                     last_lane_s;
    logic                                     end_frame_s;
    logic                                     complete_s;

    // FIFO storage and control
    logic [WORD_W-1:0]         mem_data_q [FIFO_DEPTH];
    logic [BYTES_PER_WORD-1:0] mem_keep_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     mem_last_q;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      fifo_valid_s;
    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;

    // Overlay the incoming beat onto the pack register starting at the lane pointer
    always_comb begin
        word_data_s = pack_data_q;
        word_keep_s = pack_keep_q;
        for (int j = 0; j < BYTES_PER_WORD; j++) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                if (in_valid && ((lane_q + LANE_W'(i)) == LANE_W'(j))) begin
                    word_data_s[j] = in_data[i];
                    word_keep_s[j] = 1'b1;
                end else begin
                    word_data_s[j] = word_data_s[j];
                    word_keep_s[j] = word_keep_s[j];
                end
            end
        end
    end

    // Decide whether this beat closes a word and how the FIFO moves this cycle
    always_comb begin
        last_lane_s  = (lane_q == LAST_LANE);
        end_frame_s  = (row_q == LAST_ROW);
        complete_s   = in_valid && (last_lane_s || end_frame_s);
        fifo_valid_s = (count_q != CNT_ZERO);
        pop_s        = fifo_valid_s && m_ready;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        push_s       = complete_s && ((count_q < DEPTH_CNT) || pop_s);
        drop_s       = complete_s && !push_s;
    end

    // Next state of the pack register, lane pointer and beat counter
    always_comb begin
        pack_data_d = pack_data_q;
        pack_keep_d = pack_keep_q;
        lane_d      = lane_q;
        row_d       = row_q;
        // The pack side advances whether or not the FIFO had room.
        if (complete_s) begin
            pack_data_d = '0;
            pack_keep_d = '0;
            lane_d      = LANE_ZERO;
        end else if (in_valid) begin
            pack_data_d = word_data_s;
            pack_keep_d = word_keep_s;
            lane_d      = lane_q + LANE_STEP;
        end else begin
            pack_data_d = pack_data_q;
            pack_keep_d = pack_keep_q;
            lane_d      = lane_q;
        end
        if (in_valid) begin
            row_d = end_frame_s ? ROW_ZERO : (row_q + ROW_ONE);
        end else begin
            row_d = row_q;
        end
    end

    // Next state of FIFO pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_d   = push_s ? (wr_ptr_q + ADDR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + ADDR_ONE) : rd_ptr_q;
        overflow_d = overflow_q | drop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pack-side and FIFO control registers; reset drops any partial word and queued words
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_data_q <= '0;
            pack_keep_q <= '0;
            lane_q      <= LANE_ZERO;
            row_q       <= ROW_ZERO;
            wr_ptr_q    <= ADDR_ZERO;
            rd_ptr_q    <= ADDR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
        end else begin
            pack_data_q <= pack_data_d;
            pack_keep_q <= pack_keep_d;
            lane_q      <= lane_d;
            row_q       <= row_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write; contents are only observable through a valid head entry
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_q[wr_ptr_q] <= word_data_s;
            mem_keep_q[wr_ptr_q] <= word_keep_s;
            mem_last_q[wr_ptr_q] <= end_frame_s;
        end
    end

    // Present the FIFO head; all stream fields read as zero while the FIFO is empty
    always_comb begin
        stall    = (count_q >= AFULL_CNT);
        m_valid  = fifo_valid_s;
        overflow = overflow_q;
        if (fifo_valid_s) begin
            m_data = mem_data_q[rd_ptr_q];
            m_keep = mem_keep_q[rd_ptr_q];
            m_last = mem_last_q[rd_ptr_q];
        end else begin
            m_data = {WORD_W{1'b0}};
            m_keep = {BYTES_PER_WORD{1'b0}};
            m_last = 1'b0;
        end
    end

endmodule
